// File: rtl/if_prefetch_stage_pkg.sv
// Shared constants for the instruction-fetch prefetch stage.
// Imported by the fetch stage and its entry FIFO.
package if_prefetch_stage_pkg;

    localparam int INST_BYTES = 4;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_prefetch_stage_if.sv
// Fetch-stage bus bundle: instruction RAM port, redirect input and IF/ID handshake.
// The stage takes master; the memory/decode side takes slave.
interface if_prefetch_stage_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_ready;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic              id_halt;
    logic              halted;

    modport master (
        output imem_en, imem_addr, id_valid, id_pc, id_inst, id_halt, halted,
        input  imem_data, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_en, imem_addr, id_valid, id_pc, id_inst, id_halt, halted,
        output imem_data, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_prefetch_stage_entry_fifo.sv
// Synchronous FIFO of {halt, pc, inst} entries; head word read straight from storage.
// Flush drops all entries without touching storage contents.
module if_entry_fifo
    import if_prefetch_stage_pkg::*;
#(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = din;
                wr_d = wr_q + PW'(1);
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: issues 1-cycle RAM reads, tags responses with PC/epoch,
// and queues {halt, pc, inst} for decode with redirect squash and halt stop.
module if_prefetch_stage
    import if_prefetch_stage_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                INST_W    = 32,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [INST_W-1:0] HALT_WORD = INST_W'(HALT_WORD_DEF)
) (
    input  logic                CLK,
    input  logic                RESET,
    if_prefetch_stage_if.master bus
);
    localparam int CW = cnt_w(DEPTH);
    localparam int EW = 1 + ADDR_W + INST_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic              epoch_q, epoch_d;
    logic              epoch_cur_q, epoch_cur_d;
    logic              halt_seen_q, halt_seen_d;
    logic              halted_q, halted_d;

    logic [CW-1:0] count;
    logic [CW-1:0] occ;
    logic          full, empty;
    logic [EW-1:0] head;
    logic          resp_ok, halt_now, issue, pop;

    always_comb begin
        occ      = count + inflight_q;
        resp_ok  = (inflight_q != '0) && (epoch_q == epoch_cur_q)
                   && !bus.redirect_valid;
        // A halt word arriving now must also block the issue in this cycle
        halt_now = resp_ok && (bus.imem_data == HALT_WORD);
        issue    = !RESET && !halt_seen_q && !halt_now
                   && !bus.redirect_valid && !full && (occ < CW'(DEPTH));
        pop      = !empty && bus.id_ready;

        fetch_pc_d  = fetch_pc_q;
        pc_d        = pc_q;
        inflight_d  = CW'(issue);
        epoch_d     = epoch_q;
        epoch_cur_d = epoch_cur_q;
        halt_seen_d = halt_seen_q;
        halted_d    = halted_q;

        if (issue) begin
            pc_d       = fetch_pc_q;
            epoch_d    = epoch_cur_q;
            fetch_pc_d = fetch_pc_q + ADDR_W'(INST_BYTES);
        end
        if (halt_now) halt_seen_d = 1'b1;
        if (pop && head[EW-1]) halted_d = 1'b1;
        if (bus.redirect_valid) begin
            epoch_cur_d = ~epoch_cur_q;
            fetch_pc_d  = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            halt_seen_d = 1'b0;
            halted_d    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_pc_q  <= RESET_PC;
            pc_q        <= '0;
            inflight_q  <= '0;
            epoch_q     <= 1'b0;
            epoch_cur_q <= 1'b0;
            halt_seen_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            pc_q        <= pc_d;
            inflight_q  <= inflight_d;
            epoch_q     <= epoch_d;
            epoch_cur_q <= epoch_cur_d;
            halt_seen_q <= halt_seen_d;
            halted_q    <= halted_d;
        end
    end

    if_entry_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .flush (bus.redirect_valid),
        .push  (resp_ok),
        .pop   (pop),
        .din   ({bus.imem_data == HALT_WORD, pc_q, bus.imem_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.imem_en   = issue;
    assign bus.imem_addr = {2'b00, fetch_pc_q[ADDR_W-1:2]};
    assign bus.id_valid  = !empty;
    assign bus.id_halt   = head[EW-1];
    assign bus.id_pc     = head[ADDR_W+INST_W-1:INST_W];
    assign bus.id_inst   = head[INST_W-1:0];
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: start-up, back-pressure, redirect,
// halt, mid-run reset and PC wrap (second instance with a high RESET_PC).
module tb_if_prefetch_stage;
    logic CLK;
    logic RESET;
    int   checks;
    int   errors;
    int   n;
    logic [31:0] ram [8];

    if_prefetch_stage_if #(.ADDR_W(32), .INST_W(32)) ia ();
    if_prefetch_stage_if #(.ADDR_W(32), .INST_W(32)) ib ();

    if_prefetch_stage dut_a (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (ia)
    );

    if_prefetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (ib)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Words 0..7 come from ram[]; any other word address returns A + low 28 bits
    function automatic logic [31:0] rd(input logic [31:0] wa);
        if (wa < 32'd8) return ram[wa[2:0]];
        return {4'hA, wa[27:0]};
    endfunction

    always @(posedge CLK) begin
        if (ia.imem_en) ia.imem_data <= rd(ia.imem_addr);
        if (ib.imem_en) ib.imem_data <= rd(ib.imem_addr);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RESET = 1'b1;
        ia.id_ready = 1'b1;
        ia.redirect_valid = 1'b0;
        ia.redirect_pc = '0;
        ib.id_ready = 1'b1;
        ib.redirect_valid = 1'b0;
        ib.redirect_pc = '0;
        ia.imem_data = '0;
        ib.imem_data = '0;
        for (int i = 0; i < 8; i++) ram[i] = 32'h11 * (i + 1);

        // 1: reset values, then streaming at one instruction per cycle
        repeat (3) tick();
        #1;
        check("rst_en", ia.imem_en, 0);
        check("rst_valid", ia.id_valid, 0);
        check("rst_pc", ia.id_pc, 0);
        check("rst_inst", ia.id_inst, 0);
        check("rst_halt", ia.id_halt, 0);
        check("rst_halted", ia.halted, 0);
        check("rst_b_valid", ib.id_valid, 0);
        RESET = 1'b0;
        #1;
        check("t1_en0", ia.imem_en, 1);
        check("t1_addr0", ia.imem_addr, 0);
        tick(); #1;
        check("t1_addr1", ia.imem_addr, 1);
        check("t1_valid_c1", ia.id_valid, 0);
        tick(); #1;
        check("t1_addr2", ia.imem_addr, 2);
        check("t1_valid_c2", ia.id_valid, 1);
        check("t1_pc0", ia.id_pc, 32'h0);
        check("t1_inst0", ia.id_inst, 32'h11);
        tick(); #1;
        check("t1_pc1", ia.id_pc, 32'h4);
        check("t1_inst1", ia.id_inst, 32'h22);
        tick(); #1;
        check("t1_pc2", ia.id_pc, 32'h8);
        check("t1_inst2", ia.id_inst, 32'h33);

        // 2: back-pressure fills the queue, then drains in order
        RESET = 1'b1;
        ia.id_ready = 1'b0;
        tick();
        RESET = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (ia.imem_en) n++;
            tick();
        end
        check("t2_issues", n, 4);
        ia.id_ready = 1'b1;
        #1;
        check("t2_full_en", ia.imem_en, 0);
        check("t2_pc0", ia.id_pc, 32'h0);
        tick(); #1;
        check("t2_resume_en", ia.imem_en, 1);
        check("t2_resume_addr", ia.imem_addr, 4);
        check("t2_pc4", ia.id_pc, 32'h4);
        tick(); #1;
        check("t2_pc8", ia.id_pc, 32'h8);
        tick(); #1;
        check("t2_pcc", ia.id_pc, 32'hC);
        tick(); #1;
        check("t2_pc10", ia.id_pc, 32'h10);
        check("t2_inst10", ia.id_inst, 32'h55);

        // 3: redirect with 2 queued and 1 in flight
        RESET = 1'b1;
        ia.id_ready = 1'b0;
        tick();
        RESET = 1'b0;
        tick(); tick(); tick();
        ia.redirect_valid = 1'b1;
        ia.redirect_pc = 32'h103;
        #1;
        check("t3_redir_en", ia.imem_en, 0);
        check("t3_pre_valid", ia.id_valid, 1);
        tick();
        ia.redirect_valid = 1'b0;
        #1;
        check("t3_flushed", ia.id_valid, 0);
        check("t3_en", ia.imem_en, 1);
        check("t3_addr", ia.imem_addr, 32'h40);
        tick(); #1;
        check("t3_addr2", ia.imem_addr, 32'h41);
        check("t3_drop", ia.id_valid, 0);
        tick();
        ia.id_ready = 1'b1;
        #1;
        check("t3_valid", ia.id_valid, 1);
        check("t3_pc", ia.id_pc, 32'h100);
        check("t3_inst", ia.id_inst, 32'hA000_0040);
        tick(); #1;
        check("t3_pc2", ia.id_pc, 32'h104);
        check("t3_inst2", ia.id_inst, 32'hA000_0041);

        // 4: halt word at 0xC stops fetch; redirect restarts it
        ram[3] = 32'hFFFF_FFFF;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick(); tick(); tick();
        #1;
        check("t4_addr3", ia.imem_addr, 3);
        check("t4_pc4", ia.id_pc, 32'h4);
        tick(); #1;
        check("t4_no_issue", ia.imem_en, 0);
        check("t4_pc8", ia.id_pc, 32'h8);
        check("t4_halt8", ia.id_halt, 0);
        tick(); #1;
        check("t4_pcc", ia.id_pc, 32'hC);
        check("t4_haltc", ia.id_halt, 1);
        check("t4_halted_pre", ia.halted, 0);
        check("t4_en_c5", ia.imem_en, 0);
        tick(); #1;
        check("t4_halted", ia.halted, 1);
        check("t4_empty", ia.id_valid, 0);
        check("t4_en_c6", ia.imem_en, 0);
        tick(); #1;
        check("t4_hold", ia.halted, 1);
        ia.redirect_valid = 1'b1;
        ia.redirect_pc = 32'h0;
        tick();
        ia.redirect_valid = 1'b0;
        ram[3] = 32'h44;
        #1;
        check("t4_clr", ia.halted, 0);
        check("t4_refetch", ia.imem_en, 1);
        check("t4_refetch_addr", ia.imem_addr, 0);

        // 5: reset with 3 queued and 1 in flight
        RESET = 1'b1;
        ia.id_ready = 1'b0;
        tick();
        RESET = 1'b0;
        tick(); tick(); tick(); tick();
        #1;
        check("t5_busy", ia.id_valid, 1);
        RESET = 1'b1;
        tick(); #1;
        check("t5_en", ia.imem_en, 0);
        check("t5_valid", ia.id_valid, 0);
        check("t5_pc", ia.id_pc, 0);
        check("t5_inst", ia.id_inst, 0);
        check("t5_halt", ia.id_halt, 0);
        check("t5_halted", ia.halted, 0);
        RESET = 1'b0;
        ia.id_ready = 1'b1;
        #1;
        check("t5_restart", ia.imem_addr, 0);
        check("t6_b_addr0", ib.imem_addr, 32'h3FFF_FFFE);
        tick(); #1;
        check("t6_b_addr1", ib.imem_addr, 32'h3FFF_FFFF);
        tick(); #1;
        check("t5_pc0", ia.id_pc, 32'h0);
        check("t5_inst0", ia.id_inst, 32'h11);

        // 6: PC wrap on the high RESET_PC instance
        check("t6_pc0", ib.id_pc, 32'hFFFF_FFF8);
        check("t6_inst0", ib.id_inst, 32'hAFFF_FFFE);
        tick(); #1;
        check("t6_pc1", ib.id_pc, 32'hFFFF_FFFC);
        check("t6_inst1", ib.id_inst, 32'hAFFF_FFFF);
        tick(); #1;
        check("t6_pc2", ib.id_pc, 32'h0);
        check("t6_inst2", ib.id_inst, 32'h11);
        tick(); #1;
        check("t6_pc3", ib.id_pc, 32'h4);
        check("t6_inst3", ib.id_inst, 32'h22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
